// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl
//  Purpose  : Data-memory controller between the core load/store port and a
//             word-organised synchronous data RAM. Converts byte/half/word
//             loads and stores into word accesses. Sub-word stores use
//             read-modify-write. Load data is sign- or zero-extended.
//             Misaligned requests are flagged. The core is stalled until
//             each access completes.
//  Options  : DMEM_BOUND_CHECK_EN - when defined, a request with any address
//             bit above the RAM range set is reported as an address error.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             req_ren / req_wen   load / store request (store wins)
//             req_addr            byte address
//             req_size            00 byte, 01 half, 1x word
//             req_signed          sign-extend load data when 1
//             req_wdata           right-aligned store data
//             req_rdata           registered load result
//             stall               core must hold and freeze while high
//             addr_err            one-cycle misaligned/out-of-range flag
//             ram_we/addr/din     registered RAM write enable, address, data
//             ram_dout            RAM read data
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
   parameter int RAM_AWIDTH  = 10,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_ren,
   input  logic                  req_wen,
   input  logic [31:0]           req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_wdata,
   output logic [31:0]           req_rdata,
   output logic                  stall,
   output logic                  addr_err,
   output logic                  ram_we,
   output logic [RAM_AWIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout
);

   localparam logic [2:0] c_LAT = 3'(RAM_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_WR      = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   // Request fields latched when an access is accepted
   logic [1:0]            r_off;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic                  r_is_store;
   logic [31:0]           r_wdata;
   logic [2:0]            r_cnt;

   logic [31:0]           r_rdata;
   logic                  r_ram_we;
   logic [RAM_AWIDTH-1:0] r_ram_addr;
   logic [31:0]           r_ram_din;

   logic                  w_req;
   logic                  w_misalign;
   logic                  w_oob;
   logic                  w_addr_err;
   logic                  w_accept;
   logic                  w_word_store;
   logic                  w_sample;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_load;
   logic [31:0]           w_merge;

`ifdef DMEM_BOUND_CHECK_EN
   always_comb w_oob = |req_addr[31:RAM_AWIDTH+2];
`else
   // Upper address bits alias onto the RAM; they are intentionally ignored.
   logic w_unused_hi;
   always_comb w_unused_hi = ^req_addr[31:RAM_AWIDTH+2];
   always_comb w_oob = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Request qualification
   // ------------------------------------------------------------------
   always_comb begin
      w_req        = req_ren | req_wen;
      w_word_store = req_wen & req_size[1];
      case (req_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = req_addr[0];
         default: w_misalign = |req_addr[1:0];
      endcase
      w_addr_err = ~rst & (r_state == S_IDLE) & w_req & (w_misalign | w_oob);
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && !w_addr_err) begin
               w_accept    = 1'b1;
               w_state_nxt = w_word_store ? S_WR : S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            // cnt==LAT is the first cycle ram_dout reflects ram_addr
            if (r_cnt == c_LAT) begin
               w_sample    = 1'b1;
               w_state_nxt = r_is_store ? S_WR : S_DONE;
            end
         end
         S_WR:    w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Lane extraction (loads) and lane merge (sub-word stores)
   // ------------------------------------------------------------------
   always_comb begin
      w_byte = ram_dout[{r_off, 3'b000} +: 8];
      w_half = ram_dout[{r_off[1], 4'b0000} +: 16];
      case (r_size)
         2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = ram_dout;
      endcase

      w_merge = ram_dout;
      case (r_size)
         2'b00:   w_merge[{r_off, 3'b000} +: 8]     = r_wdata[7:0];
         2'b01:   w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merge = r_wdata;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_off      <= 2'b00;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_is_store <= 1'b0;
         r_wdata    <= 32'h0;
         r_cnt      <= 3'd0;
         r_rdata    <= 32'h0;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= 32'h0;
      end else begin
         r_state  <= w_state_nxt;
         // Write enable is only ever set for the single cycle spent in WR
         r_ram_we <= 1'b0;

         if (w_accept) begin
            r_off      <= req_addr[1:0];
            r_size     <= req_size;
            r_signed   <= req_signed;
            r_is_store <= req_wen;
            r_wdata    <= req_wdata;
            r_ram_addr <= req_addr[RAM_AWIDTH+1:2];
            r_cnt      <= 3'd0;
            if (w_word_store) begin
               r_ram_din <= req_wdata;
               r_ram_we  <= 1'b1;
            end
         end

         if (r_state == S_RD_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
         end

         if (w_sample) begin
            if (r_is_store) begin
               r_ram_din <= w_merge;
               r_ram_we  <= 1'b1;
            end else begin
               r_rdata <= w_load;
            end
         end
      end
   end

   always_comb begin
      stall     = ~rst & ((r_state == S_RD_WAIT) || (r_state == S_WR) ||
                          ((r_state == S_IDLE) && w_req && !w_addr_err));
      addr_err  = w_addr_err;
      req_rdata = r_rdata;
      ram_we    = r_ram_we;
      ram_addr  = r_ram_addr;
      ram_din   = r_ram_din;
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_ctrl
//  Purpose  : Self-checking bench for dmem_ctrl with a synchronous RAM model
//             and a per-cycle reference model of the load/store protocol.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

   localparam int AW  = 10;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_ren, req_wen, req_signed;
   logic [31:0]   req_addr, req_wdata, req_rdata;
   logic [1:0]    req_size;
   logic          stall, addr_err, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din, ram_dout;

   dmem_ctrl #(.RAM_AWIDTH(AW), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
      .req_rdata(req_rdata), .stall(stall), .addr_err(addr_err),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // ---------------- RAM model with backdoor load port ----------------
   logic [31:0]   mem [0:(1<<AW)-1];
   logic [31:0]   rd_pipe [0:LAT-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [31:0]   bd_data = '0;
   int            we_cnt = 0;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_we) we_cnt <= we_cnt + 1;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_dout = rd_pipe[LAT-1];

   // ---------------- bookkeeping ----------------
   int n_cmp = 0, n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:(1<<AW)-1];
   bit          chk_en = 1'b0;
   int          cyc = 0, t0 = -1000;
   int          m_nstall = 0;
   bit          m_err = 0, m_load = 0, m_store = 0;
   logic [31:0] m_rd_prev = 0, m_rd_new = 0, m_din = 0, committed = 0;
   logic [AW-1:0] m_waddr = '0;

   function automatic bit f_misalign(input logic [31:0] a, input logic [1:0] sz);
      if (sz == 2'b00) return 1'b0;
      if (sz == 2'b01) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   function automatic logic [31:0] f_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input bit sgn);
      logic [31:0] s, v;
      s = w >> (8 * off);
      if (sz == 2'b00) begin
         v = s & 32'hFF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = s & 32'hFFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else v = w;
      return v;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] d,
                                           input logic [1:0] off, input logic [1:0] sz);
      logic [31:0] m;
      m = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      m = m << (8 * off);
      return (w & ~m) | ((d << (8 * off)) & m);
   endfunction

   // One compare process: every cycle the outputs are checked against the model.
   always @(negedge clk) begin
      int k;
      k = cyc - t0;
      if (chk_en) begin
         check("stall", {31'b0, stall}, {31'b0, (k < m_nstall)});
         check("addr_err", {31'b0, addr_err}, {31'b0, (m_err && k == 0)});
         check("ram_we", {31'b0, ram_we}, {31'b0, (m_store && k == m_nstall - 1)});
         if (m_store && k == m_nstall - 1) begin
            check("ram_addr", {22'b0, ram_addr}, {22'b0, m_waddr});
            check("ram_din", ram_din, m_din);
         end
         check("req_rdata", req_rdata, (m_load && k >= m_nstall) ? m_rd_new : m_rd_prev);
      end
      cyc++;
   end

   task automatic poke(input int idx, input logic [31:0] v);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = AW'(idx); bd_data = v;
      ref_mem[idx] = v;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic access(input bit wr, input bit both, input logic [31:0] a,
                         input logic [1:0] sz, input bit sgn, input logic [31:0] wd);
      logic [31:0] w;
      int          idx, nh;
      bit          err;
      @(posedge clk); #1;
      idx = int'(a[AW+1:2]);
      err = f_misalign(a, sz);
`ifdef DMEM_BOUND_CHECK_EN
      err = err || (a[31:AW+2] != '0);
`endif
      w         = ref_mem[idx];
      m_rd_prev = committed;
      m_err     = err;
      m_load    = !wr && !err;
      m_store   = wr && !err;
      m_rd_new  = f_ext(w, a[1:0], sz, sgn);
      m_din     = f_merge(w, wd, a[1:0], sz);
      m_waddr   = AW'(idx);
      m_nstall  = err ? 0 : !wr ? LAT + 2 : sz[1] ? 2 : LAT + 3;
      req_ren = !wr || both; req_wen = wr; req_addr = a;
      req_size = sz; req_signed = sgn; req_wdata = wd;
      t0 = cyc;
      nh = (m_nstall > 0) ? m_nstall : 1;
      repeat (nh) @(posedge clk);
      #1;
      req_ren = 1'b0; req_wen = 1'b0;
      repeat (2) @(posedge clk);
      if (m_store) ref_mem[idx] = m_din;
      if (m_load) committed = m_rd_new;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] exp_b;
      int          we0;
      rst = 1'b0;
      req_ren = 1'b1; req_wen = 1'b0; req_addr = 32'h23; req_size = 2'b10;
      req_signed = 1'b0; req_wdata = 32'h0;
      #2 rst = 1'b1;
      #1;
      // Reset state: outputs cleared, stall/addr_err forced low despite request
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_addr_err", {31'b0, addr_err}, 32'h0);
      check("rst_ram_we", {31'b0, ram_we}, 32'h0);
      check("rst_ram_addr", {22'b0, ram_addr}, 32'h0);
      check("rst_ram_din", ram_din, 32'h0);
      check("rst_rdata", req_rdata, 32'h0);
      req_ren = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      poke(0, 32'h0102_0304);
      poke(4, 32'h8899_AABB);
      poke(8, 32'h0000_0000);
      poke(12, 32'hCAFE_F00D);
      chk_en = 1'b1;

      access(0, 0, 32'h13, 2'b00, 1, 0);            check("lb_lit", req_rdata, 32'hFFFF_FF88);
      access(0, 0, 32'h13, 2'b00, 0, 0);            check("lbu_lit", req_rdata, 32'h0000_0088);
      access(0, 0, 32'h12, 2'b01, 1, 0);            check("lh_lit", req_rdata, 32'hFFFF_8899);
      access(0, 0, 32'h10, 2'b00, 0, 0);            check("lbu0_lit", req_rdata, 32'h0000_00BB);
      access(1, 0, 32'h20, 2'b10, 0, 32'hDEAD_BEEF); check("sw_mem", mem[8], 32'hDEAD_BEEF);
      access(0, 0, 32'h20, 2'b10, 0, 0);            check("lw_lit", req_rdata, 32'hDEAD_BEEF);
      access(1, 0, 32'h22, 2'b01, 0, 32'hFFFF_1234); check("sh_mem", mem[8], 32'h1234_BEEF);
      access(1, 1, 32'h21, 2'b00, 0, 32'hAAAA_AA55); check("sb_mem", mem[8], 32'h1234_55EF);
      access(0, 0, 32'h20, 2'b01, 1, 0);            check("lh0_lit", req_rdata, 32'h0000_55EF);
      access(0, 0, 32'h23, 2'b00, 1, 0);            check("lb3_lit", req_rdata, 32'h0000_0012);
      access(0, 0, 32'h20, 2'b11, 0, 0);            check("lw11_lit", req_rdata, 32'h1234_55EF);

      // Misaligned requests: no access, no write, rdata unchanged
      we0 = we_cnt;
      access(0, 0, 32'h22, 2'b10, 0, 0);
      access(0, 0, 32'h23, 2'b01, 1, 0);
      access(1, 0, 32'h21, 2'b10, 0, 32'h1111_1111);
      check("err_rdata", req_rdata, 32'h1234_55EF);
      check("err_no_we", 32'(we_cnt - we0), 32'h0);
      check("err_mem", mem[8], 32'h1234_55EF);

      // Upper address bits
      access(0, 0, 32'h0000_1000, 2'b10, 0, 0);
`ifdef DMEM_BOUND_CHECK_EN
      exp_b = 32'h1234_55EF;
`else
      exp_b = 32'h0102_0304;
`endif
      check("bound_lw", req_rdata, exp_b);

      // Reset during RD_WAIT of a byte store
      chk_en = 1'b0;
      we0 = we_cnt;
      @(posedge clk); #1;
      req_wen = 1'b1; req_addr = 32'h31; req_size = 2'b00; req_wdata = 32'h77;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_stall", {31'b0, stall}, 32'h0);
      check("midrst_we", {31'b0, ram_we}, 32'h0);
      req_wen = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_we", 32'(we_cnt - we0), 32'h0);
      check("midrst_mem", mem[12], 32'hCAFE_F00D);
      check("midrst_rdata", req_rdata, 32'h0);
      check("midrst_stall_after", {31'b0, stall}, 32'h0);
      committed = 32'h0; m_rd_prev = 32'h0;
      m_load = 0; m_store = 0; m_err = 0; m_nstall = 0;
      chk_en = 1'b1;

      access(0, 0, 32'h10, 2'b10, 0, 0);            check("post_rst_lw", req_rdata, 32'h8899_AABB);
      access(1, 0, 32'h32, 2'b01, 0, 32'h0000_BEAD); check("post_rst_sh", mem[12], 32'hBEAD_F00D);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
